// File: rtl/apb_memif_mux.sv
// APB slave bridge that decodes the address into one of NUM_REGIONS memory
// ports and drives a level req/ack handshake to the selected port.
// APB responses (pready/prdata/pslverr) all come from flops, so there is no
// combinational path from a memory port back to the APB bus.
// Optional: define APB_MEMIF_MUX_TIMEOUT_EN to abort a hung target after
// TIMEOUT_CYCLES busy cycles with a slave error.
module apb_memif_mux #(
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    NUM_REGIONS      = 4,
    parameter int                    REGION_SIZE_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int                    TIMEOUT_CYCLES   = 64
) (
    input  logic                              clk_i,
    input  logic                              arst_i,
    input  logic                              psel_i,
    input  logic                              penable_i,
    input  logic [ADDR_WIDTH-1:0]             paddr_i,
    input  logic                              pwrite_i,
    input  logic [DATA_WIDTH-1:0]             pwdata_i,
    input  logic [DATA_WIDTH/8-1:0]           pstrb_i,
    output logic                              pready_o,
    output logic [DATA_WIDTH-1:0]             prdata_o,
    output logic                              pslverr_o,
    output logic [NUM_REGIONS-1:0]            mreq_o,
    output logic [REGION_SIZE_LOG2-1:0]       maddr_o,
    output logic                              mwe_o,
    output logic [DATA_WIDTH-1:0]             mwdata_o,
    output logic [DATA_WIDTH/8-1:0]           mstrb_o,
    input  logic [NUM_REGIONS-1:0]            mack_i,
    input  logic [NUM_REGIONS*DATA_WIDTH-1:0] mrdata_i,
    input  logic [NUM_REGIONS-1:0]            mresp_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGIONS_A = ADDR_WIDTH'(NUM_REGIONS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [REGION_SIZE_LOG2-1:0] maddr_q, maddr_d;
    logic                        mwe_q, mwe_d;
    logic [DATA_WIDTH-1:0]       mwdata_q, mwdata_d;
    logic [STRB_W-1:0]           mstrb_q, mstrb_d;
    logic [DATA_WIDTH-1:0]       prdata_q, prdata_d;
    logic                        pslverr_q, pslverr_d;
    logic                        pready_q, pready_d;

    logic [ADDR_WIDTH-1:0]       off;
    logic [ADDR_WIDTH-1:0]       region;
    logic                        hit;
    logic                        sel_ack;
    logic                        sel_resp;
    logic [DATA_WIDTH-1:0]       sel_rdata;
    logic                        timeout_hit;

    // Address decode; addresses below BASE_ADDR wrap to a huge offset and miss
    always_comb begin
        off    = paddr_i - BASE_ADDR;
        region = off >> REGION_SIZE_LOG2;
        hit    = (region < NUM_REGIONS_A);
    end

    // Pick the handshake inputs of the region currently being served
    always_comb begin
        sel_ack   = mack_i[idx_q];
        sel_resp  = mresp_i[idx_q];
        sel_rdata = mrdata_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
    end

`ifdef APB_MEMIF_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count busy cycles; the count restarts from zero on every entry to BUSY
    always_comb begin
        cnt_d       = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
        timeout_hit = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Busy-cycle counter register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    // Without the counter a busy access waits forever; the expression is
    // constant false for any sane TIMEOUT_CYCLES
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // Next-state logic, request latching and APB response capture
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        maddr_d   = maddr_q;
        mwe_d     = mwe_q;
        mwdata_d  = mwdata_q;
        mstrb_d   = mstrb_q;
        prdata_d  = prdata_q;
        pslverr_d = 1'b0;
        pready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel_i && penable_i) begin
                    if (hit) begin
                        idx_d    = region[IDX_W-1:0];
                        maddr_d  = off[REGION_SIZE_LOG2-1:0];
                        mwe_d    = pwrite_i;
                        mwdata_d = pwdata_i;
                        mstrb_d  = pstrb_i;
                        state_d  = BUSY;
                    end else begin
                        prdata_d  = '0;
                        pslverr_d = 1'b1;
                        pready_d  = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            BUSY: begin
                if (sel_ack) begin
                    prdata_d  = mwe_q ? '0 : sel_rdata;
                    pslverr_d = sel_resp;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end else if (timeout_hit) begin
                    prdata_d  = '0;
                    pslverr_d = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and registered APB response
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            maddr_q   <= '0;
            mwe_q     <= 1'b0;
            mwdata_q  <= '0;
            mstrb_q   <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            pready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            maddr_q   <= maddr_d;
            mwe_q     <= mwe_d;
            mwdata_q  <= mwdata_d;
            mstrb_q   <= mstrb_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            pready_q  <= pready_d;
        end
    end

    // One-hot request only while BUSY, so it drops as soon as DONE or reset hits
    always_comb begin
        mreq_o = '0;
        if (state_q == BUSY) mreq_o[idx_q] = 1'b1;
    end

    assign maddr_o   = maddr_q;
    assign mwe_o     = mwe_q;
    assign mwdata_o  = mwdata_q;
    assign mstrb_o   = mstrb_q;
    assign pready_o  = pready_q;
    assign prdata_o  = prdata_q;
    assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_memif_mux.sv
// Directed testbench for apb_memif_mux with default parameters.
// Honours APB_MEMIF_MUX_TIMEOUT_EN to pick the hung-target expectation.
module tb_apb_memif_mux;

    logic         clk_i = 1'b0;
    logic         arst_i;
    logic         psel_i, penable_i, pwrite_i;
    logic [31:0]  paddr_i, pwdata_i;
    logic [3:0]   pstrb_i;
    logic         pready_o, pslverr_o, mwe_o;
    logic [31:0]  prdata_o, mwdata_o;
    logic [3:0]   mreq_o, mstrb_o, mack_i, mresp_i;
    logic [11:0]  maddr_o;
    logic [127:0] mrdata_i;

    int total = 0;
    int bad   = 0;

    apb_memif_mux dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .psel_i(psel_i), .penable_i(penable_i), .paddr_i(paddr_i),
        .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
        .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
        .mreq_o(mreq_o), .maddr_o(maddr_o), .mwe_o(mwe_o),
        .mwdata_o(mwdata_o), .mstrb_o(mstrb_o),
        .mack_i(mack_i), .mrdata_i(mrdata_i), .mresp_i(mresp_i)
    );

    // 10 ns clock
    always #5 clk_i = ~clk_i;

    // Step to 1 ns after the next rising edge: drive and sample point
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    // Setup cycle then access cycle; returns inside the access cycle T
    task automatic apb_access(input logic [31:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [3:0] strb);
        next_cycle();
        psel_i    = 1'b1;
        penable_i = 1'b0;
        paddr_i   = addr;
        pwrite_i  = wr;
        pwdata_i  = wdata;
        pstrb_i   = strb;
        next_cycle();
        penable_i = 1'b1;
    endtask

    task automatic apb_end();
        psel_i    = 1'b0;
        penable_i = 1'b0;
    endtask

    task automatic test_reset();
        arst_i = 1'b1;
        apb_end();
        paddr_i = '0; pwrite_i = 1'b0; pwdata_i = '0; pstrb_i = '0;
        mack_i = '0; mresp_i = '0; mrdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if ({mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o, pready_o, pslverr_o, prdata_o} !== 87'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got mreq=%b pready=%b prdata=%h expected all zero",
                     mreq_o, pready_o, prdata_o);
        end
        arst_i = 1'b0;
        next_cycle();
        total++;
        if ({mreq_o, pready_o} !== 5'd0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle: got mreq=%b pready=%b expected 0", mreq_o, pready_o);
        end
    endtask

    task automatic test_read_region2();
        apb_access(32'h0000_2010, 1'b0, 32'h0, 4'h0);
        total++;
        if (mreq_o !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rd2_no_req_in_access: got %b expected 0000", mreq_o);
        end
        next_cycle();
        total++;
        if ({mreq_o, maddr_o, mwe_o, pready_o} !== {4'b0100, 12'h010, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL rd2_busy: got mreq=%b maddr=%h mwe=%b pready=%b expected 0100 010 0 0",
                     mreq_o, maddr_o, mwe_o, pready_o);
        end
        mack_i = 4'b0100;
        mrdata_i[64 +: 32] = 32'hDEAD_BEEF;
        next_cycle();
        mack_i = '0;
        total++;
        if ({pready_o, pslverr_o, prdata_o, mreq_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL rd2_done: got pready=%b err=%b prdata=%h mreq=%b expected 1 0 deadbeef 0000",
                     pready_o, pslverr_o, prdata_o, mreq_o);
        end
        next_cycle();
        apb_end();
        total++;
        if ({pready_o, pslverr_o, prdata_o} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
            bad++;
            $display("[TB] FAIL rd2_after: got pready=%b err=%b prdata=%h expected 0 0 deadbeef",
                     pready_o, pslverr_o, prdata_o);
        end
    endtask

    task automatic test_miss();
        logic [31:0] addrs [2];
        addrs[0] = 32'h0000_4000;
        addrs[1] = 32'hFFFF_FFF0;
        for (int i = 0; i < 2; i++) begin
            apb_access(addrs[i], 1'b0, 32'h0, 4'h0);
            next_cycle();
            total++;
            if ({pready_o, pslverr_o, prdata_o, mreq_o} !== {1'b1, 1'b1, 32'h0, 4'b0000}) begin
                bad++;
                $display("[TB] FAIL miss_%0d: got pready=%b err=%b prdata=%h mreq=%b expected 1 1 0 0000",
                         i, pready_o, pslverr_o, prdata_o, mreq_o);
            end
            next_cycle();
            apb_end();
            total++;
            if ({pready_o, pslverr_o, mreq_o} !== 6'd0) begin
                bad++;
                $display("[TB] FAIL miss_after_%0d: got pready=%b err=%b mreq=%b expected 0 0 0000",
                         i, pready_o, pslverr_o, mreq_o);
            end
        end
    endtask

    task automatic test_write();
        mrdata_i[96 +: 32] = 32'hA5A5_A5A5;
        apb_access(32'h0000_3FFC, 1'b1, 32'h1234_5678, 4'b0101);
        for (int i = 1; i <= 3; i++) begin
            next_cycle();
            if (i == 1) begin
                pwdata_i = 32'hFFFF_FFFF;
                pstrb_i  = 4'b1010;
                paddr_i  = 32'h0;
            end
            total++;
            if ({mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o, pready_o} !==
                {4'b1000, 12'hFFC, 1'b1, 32'h1234_5678, 4'b0101, 1'b0}) begin
                bad++;
                $display("[TB] FAIL wr_busy_%0d: got mreq=%b maddr=%h mwe=%b wdata=%h strb=%b pready=%b expected 1000 ffc 1 12345678 0101 0",
                         i, mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o, pready_o);
            end
            if (i == 3) mack_i = 4'b1000;
        end
        next_cycle();
        mack_i = '0;
        total++;
        if ({pready_o, pslverr_o, prdata_o, mreq_o} !== {1'b1, 1'b0, 32'h0, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL wr_done: got pready=%b err=%b prdata=%h mreq=%b expected 1 0 0 0000",
                     pready_o, pslverr_o, prdata_o, mreq_o);
        end
        next_cycle();
        apb_end();
        total++;
        if (pready_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wr_single_pulse: got pready=%b expected 0", pready_o);
        end
    endtask

    task automatic test_stray_ack();
        mrdata_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        apb_access(32'h0000_1020, 1'b0, 32'h0, 4'h0);
        mack_i = 4'b1001;
        next_cycle();
        total++;
        if ({mreq_o, maddr_o} !== {4'b0010, 12'h020}) begin
            bad++;
            $display("[TB] FAIL stray_busy: got mreq=%b maddr=%h expected 0010 020", mreq_o, maddr_o);
        end
        next_cycle();
        total++;
        if ({pready_o, mreq_o} !== {1'b0, 4'b0010}) begin
            bad++;
            $display("[TB] FAIL stray_ignored: got pready=%b mreq=%b expected 0 0010", pready_o, mreq_o);
        end
        mack_i = 4'b0010;
        mresp_i = 4'b0010;
        mrdata_i[32 +: 32] = 32'h1111_2222;
        next_cycle();
        mack_i = '0;
        mresp_i = '0;
        total++;
        if ({pready_o, pslverr_o, prdata_o, mreq_o} !== {1'b1, 1'b1, 32'h1111_2222, 4'b0000}) begin
            bad++;
            $display("[TB] FAIL stray_done_err: got pready=%b err=%b prdata=%h mreq=%b expected 1 1 11112222 0000",
                     pready_o, pslverr_o, prdata_o, mreq_o);
        end
        next_cycle();
        apb_end();
    endtask

    task automatic test_reset_busy();
        apb_access(32'h0000_0104, 1'b1, 32'hCAFE_F00D, 4'b1111);
        next_cycle();
        total++;
        if (mreq_o !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL rst_pre_busy: got mreq=%b expected 0001", mreq_o);
        end
        arst_i = 1'b1;
        #1;
        total++;
        if ({mreq_o, maddr_o, mwe_o, mwdata_o, mstrb_o, pready_o, pslverr_o, prdata_o} !== 87'd0) begin
            bad++;
            $display("[TB] FAIL rst_async_clear: got mreq=%b maddr=%h mwe=%b wdata=%h prdata=%h expected all zero",
                     mreq_o, maddr_o, mwe_o, mwdata_o, prdata_o);
        end
        #1;
        arst_i = 1'b0;
        apb_end();
        next_cycle();
        total++;
        if ({mreq_o, pready_o} !== 5'd0) begin
            bad++;
            $display("[TB] FAIL rst_no_completion: got mreq=%b pready=%b expected 0000 0", mreq_o, pready_o);
        end
        mrdata_i[0 +: 32] = 32'h0BAD_CAFE;
        apb_access(32'h0000_0008, 1'b0, 32'h0, 4'h0);
        next_cycle();
        next_cycle();
        total++;
        if ({mreq_o, maddr_o, pready_o} !== {4'b0001, 12'h008, 1'b0}) begin
            bad++;
            $display("[TB] FAIL rst_next_busy: got mreq=%b maddr=%h pready=%b expected 0001 008 0",
                     mreq_o, maddr_o, pready_o);
        end
        mack_i = 4'b0001;
        next_cycle();
        mack_i = '0;
        total++;
        if ({pready_o, pslverr_o, prdata_o} !== {1'b1, 1'b0, 32'h0BAD_CAFE}) begin
            bad++;
            $display("[TB] FAIL rst_next_done: got pready=%b err=%b prdata=%h expected 1 0 0badcafe",
                     pready_o, pslverr_o, prdata_o);
        end
        next_cycle();
        apb_end();
    endtask

    task automatic test_psel_drop();
        apb_access(32'h0000_2000, 1'b0, 32'h0, 4'h0);
        next_cycle();
        apb_end();
        total++;
        if (mreq_o !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL drop_busy: got mreq=%b expected 0100", mreq_o);
        end
        next_cycle();
        total++;
        if (mreq_o !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL drop_still_busy: got mreq=%b expected 0100", mreq_o);
        end
        mack_i = 4'b0100;
        mrdata_i[64 +: 32] = 32'h7777_8888;
        next_cycle();
        mack_i = '0;
        total++;
        if ({pready_o, pslverr_o, prdata_o} !== {1'b1, 1'b0, 32'h7777_8888}) begin
            bad++;
            $display("[TB] FAIL drop_done: got pready=%b err=%b prdata=%h expected 1 0 77778888",
                     pready_o, pslverr_o, prdata_o);
        end
        next_cycle();
        total++;
        if ({pready_o, mreq_o} !== 5'd0) begin
            bad++;
            $display("[TB] FAIL drop_idle: got pready=%b mreq=%b expected 0 0000", pready_o, mreq_o);
        end
    endtask

    task automatic test_back_to_back();
        mrdata_i[0 +: 32] = 32'h0000_0001;
        apb_access(32'h0000_0000, 1'b0, 32'h0, 4'h0);
        next_cycle();
        mack_i = 4'b0001;
        next_cycle();
        mack_i = '0;
        total++;
        if ({pready_o, prdata_o} !== {1'b1, 32'h0000_0001}) begin
            bad++;
            $display("[TB] FAIL b2b_first: got pready=%b prdata=%h expected 1 00000001", pready_o, prdata_o);
        end
        paddr_i   = 32'h0000_1004;
        penable_i = 1'b0;
        next_cycle();
        penable_i = 1'b1;
        total++;
        if ({pready_o, mreq_o} !== 5'd0) begin
            bad++;
            $display("[TB] FAIL b2b_idle: got pready=%b mreq=%b expected 0 0000", pready_o, mreq_o);
        end
        next_cycle();
        total++;
        if ({mreq_o, maddr_o} !== {4'b0010, 12'h004}) begin
            bad++;
            $display("[TB] FAIL b2b_second_busy: got mreq=%b maddr=%h expected 0010 004", mreq_o, maddr_o);
        end
        mack_i = 4'b0010;
        mrdata_i[32 +: 32] = 32'h0000_0002;
        next_cycle();
        mack_i = '0;
        total++;
        if ({pready_o, pslverr_o, prdata_o} !== {1'b1, 1'b0, 32'h0000_0002}) begin
            bad++;
            $display("[TB] FAIL b2b_second_done: got pready=%b err=%b prdata=%h expected 1 0 00000002",
                     pready_o, pslverr_o, prdata_o);
        end
        next_cycle();
        apb_end();
    endtask

    task automatic test_hung_target();
        int cnt;
        cnt = 0;
        mack_i = '0;
        apb_access(32'h0000_3000, 1'b0, 32'h0, 4'h0);
`ifdef APB_MEMIF_MUX_TIMEOUT_EN
        for (int i = 0; i < 200; i++) begin
            next_cycle();
            if (mreq_o == 4'b1000) cnt++;
            else break;
        end
        total++;
        if (cnt !== 64) begin
            bad++;
            $display("[TB] FAIL timeout_req_cycles: got %0d expected 64", cnt);
        end
        total++;
        if ({pready_o, pslverr_o, prdata_o} !== {1'b1, 1'b1, 32'h0}) begin
            bad++;
            $display("[TB] FAIL timeout_done: got pready=%b err=%b prdata=%h expected 1 1 0",
                     pready_o, pslverr_o, prdata_o);
        end
        next_cycle();
        apb_end();
`else
        for (int i = 0; i < 1000; i++) begin
            next_cycle();
            if (mreq_o == 4'b1000 && !pready_o) cnt++;
        end
        total++;
        if (cnt !== 1000) begin
            bad++;
            $display("[TB] FAIL no_timeout_busy: got %0d busy cycles expected 1000", cnt);
        end
        apb_end();
        arst_i = 1'b1;
        #2;
        arst_i = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_read_region2();
        test_miss();
        test_write();
        test_stray_ack();
        test_reset_busy();
        test_psel_drop();
        test_back_to_back();
        test_hung_target();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_memif_mux.md
Name: apb_memif_mux

Overview:
Parametrised APB slave to multi-region memory bridge. It replaces the single-port APB memory interface when several memory-mapped targets share one APB slot. It decodes the APB address into one of NUM_REGIONS memory ports and drives a level req/ack handshake to that port. It returns fully registered pready/prdata/pslverr, so there is no combinational path from memory to APB. Decode misses and, optionally, hung targets are reported as slave errors.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, data width; multiple of 8
NUM_REGIONS, 4, number of memory ports (1..16)
REGION_SIZE_LOG2, 12, log2 of bytes per region; also the width of maddr_o
BASE_ADDR, 0, base of region 0; aligned to NUM_REGIONS*2^REGION_SIZE_LOG2
TIMEOUT_CYCLES, 64, max cycles in BUSY before abort (only with timeout feature)

Ports:
clk_i  in  1  clock, rising edge
arst_i  in  1  asynchronous reset, active-high
psel_i  in  1  APB select
penable_i  in  1  APB enable
paddr_i  in  ADDR_WIDTH  APB address
pwrite_i  in  1  APB write
pwdata_i  in  DATA_WIDTH  APB write data
pstrb_i  in  DATA_WIDTH/8  APB byte strobes
pready_o  out  1  APB ready
prdata_o  out  DATA_WIDTH  APB read data
pslverr_o  out  1  APB slave error
mreq_o  out  NUM_REGIONS  per-region request, one-hot or zero
maddr_o  out  REGION_SIZE_LOG2  offset within region (shared)
mwe_o  out  1  write enable (shared)
mwdata_o  out  DATA_WIDTH  write data (shared)
mstrb_o  out  DATA_WIDTH/8  byte strobes (shared)
mack_i  in  NUM_REGIONS  per-region acknowledge
mrdata_i  in  NUM_REGIONS*DATA_WIDTH  per-region read data; region k at [k*DATA_WIDTH +: DATA_WIDTH]
mresp_i  in  NUM_REGIONS  per-region error, valid with mack

Behaviour:
- Reset (async, while arst_i=1): state IDLE. pready_o=0, prdata_o=0, pslverr_o=0, mreq_o=0, maddr_o/mwe_o/mwdata_o/mstrb_o=0, timeout counter=0. Reset mid-transaction drops mreq_o immediately, with no completion.
- Decode: off = paddr_i - BASE_ADDR (ADDR_WIDTH bits, unsigned wrap). Hit iff off >> REGION_SIZE_LOG2 < NUM_REGIONS; idx = off >> REGION_SIZE_LOG2. An address below BASE_ADDR wraps to a large off and is a miss.
- FSM states: IDLE, BUSY, DONE.
- IDLE, on psel_i&penable_i (access phase):
  - Hit: latch idx, maddr=off[REGION_SIZE_LOG2-1:0], mwe, mwdata, mstrb; go to BUSY.
  - Miss: set err=1, rdata=0; go to DONE. No mreq is issued.
- BUSY: mreq_o[idx]=1, all other bits 0. Memory-side outputs are held stable from the latches, not from the APB bus.
- BUSY, on mack_i[idx]: capture prdata=mrdata_i[idx] (forced 0 if mwe), pslverr=mresp_i[idx]; go to DONE. mreq_o drops in the DONE cycle.
- mack_i on a non-selected region, or in IDLE/DONE, is ignored.
- DONE: pready_o=1 for exactly one cycle, with prdata_o/pslverr_o valid; then IDLE.
- Outside DONE: pready_o=0, pslverr_o=0. prdata_o holds its last captured value.
- Latency: access phase starts at cycle T. mreq_o is high from T+1. With ack in cycle T+k (k>=1), pready_o is high in T+k+1. Minimum access phase is 3 cycles.
- Miss: pready_o is high at T+1 with pslverr_o=1.
- psel_i deasserted while BUSY (protocol violation): the memory transaction still completes and DONE pulses normally. A new access is accepted only from IDLE.
- Back-to-back: a setup phase that coincides with DONE is legal. That access phase is taken from IDLE in the next cycle.

Optional Feature:
- Macro APB_MEMIF_MUX_TIMEOUT_EN.
- Defined: the counter clears on entering BUSY and increments each BUSY cycle. If it reaches TIMEOUT_CYCLES without mack_i[idx], mreq_o drops and the FSM goes to DONE with pslverr_o=1, prdata_o=0. An ack in the same cycle the count reaches TIMEOUT_CYCLES takes priority and completes normally.
- Not defined: no counter logic exists, and BUSY waits indefinitely for mack_i[idx].

Test Plan:
- Read region 2 (default params), paddr=0x2010, mack_i[2] in the first BUSY cycle, mrdata_i[2]=0xDEADBEEF -> maddr_o=0x010, mreq_o=4'b0100 for one cycle, pready_o at access+2 with prdata_o=0xDEADBEEF, pslverr_o=0.
- Write paddr=0x3FFC, pwdata=0x12345678, pstrb=4'b0101, ack after 3 BUSY cycles -> mreq_o=4'b1000 for 3 cycles with mwe_o=1, mwdata_o=0x12345678, mstrb_o=4'b0101 stable; pready_o one cycle; prdata_o=0.
- Decode miss, paddr=0x4000 -> mreq_o stays 0; pready_o=1 and pslverr_o=1 in the cycle after access start.
- Read region 1 with mack_i[0]=1 and mack_i[3]=1 asserted, then mack_i[1]=1 with mresp_i[1]=1 -> stray acks ignored; completes on mack_i[1] with pslverr_o=1.
- arst_i pulsed while BUSY with mreq_o=4'b0001 -> mreq_o=0 and all outputs 0 asynchronously; the next access behaves normally.
- With APB_MEMIF_MUX_TIMEOUT_EN, TIMEOUT_CYCLES=64, no ack -> mreq_o high for 64 cycles, then pready_o=1, pslverr_o=1, prdata_o=0. Without the macro -> still BUSY after 1000 cycles.
